// File: rtl/lut_cluster_cfg_pkg.sv
// Shared types and helpers for the run-time configurable LUT cluster.
package lut_cluster_cfg_pkg;

  typedef enum logic [1:0] {
    ST_UNCONFIG = 2'd0,
    ST_LOADING  = 2'd1,
    ST_ACTIVE   = 2'd2
  } cfg_state_e;

  // Length of the whole configuration chain: one select bit plus a 2**K mask per BLE.
  function automatic int unsigned cfg_bits(input int unsigned k, input int unsigned n);
    return n * ((32'd1 << k) + 32'd1);
  endfunction

endpackage

// File: rtl/lut_cluster_cfg_if.sv
// Configuration and data bus of the LUT cluster; cfg_out exists only with CFG_CHAIN_OUT_EN.
interface lut_cluster_cfg_if #(
  parameter int unsigned K = 6,
  parameter int unsigned N = 4
) ();

  logic           cfg_start;
  logic           cfg_valid;
  logic           cfg_data;
  logic           cfg_active;
  logic           cfg_done;
  logic [N*K-1:0] lut_in;
  logic [N-1:0]   out;
`ifdef CFG_CHAIN_OUT_EN
  logic           cfg_out;

  modport master (
    output cfg_start, cfg_valid, cfg_data, lut_in,
    input  cfg_active, cfg_done, out, cfg_out
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, lut_in,
    output cfg_active, cfg_done, out, cfg_out
  );
`else
  modport master (
    output cfg_start, cfg_valid, cfg_data, lut_in,
    input  cfg_active, cfg_done, out
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, lut_in,
    output cfg_active, cfg_done, out
  );
`endif

endinterface

// File: rtl/lut_cluster_cfg_ble_cell.sv
// Basic logic element (ble_cell): K-input LUT, D flip-flop and output select.
module lut_cluster_cfg_ble_cell #(
  parameter int unsigned K             = 6,
  parameter logic        INITIAL_VALUE = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [(1 << K)-1:0]    i_mask,
  input  logic                   i_ff_sel,
  input  logic [K-1:0]           i_lut_in,
  input  logic                   i_enable,
  input  logic                   i_load_init,
  output logic                   o_out_c
);

  logic w_lut;
  logic r_q;

  assign w_lut = i_mask[i_lut_in];

  // Reload to the initial value takes priority over normal capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= INITIAL_VALUE;
    end else if (i_load_init) begin
      r_q <= INITIAL_VALUE;
    end else if (i_enable) begin
      r_q <= w_lut;
    end
  end

  assign o_out_c = i_ff_sel ? r_q : w_lut;

endmodule

// File: rtl/lut_cluster_cfg.sv
// Cluster of N BLEs whose masks/selects load through a serial chain.
// Optional CFG_CHAIN_OUT_EN exposes the shifted-out bit as cfg_out for daisy-chaining.
module lut_cluster_cfg
  import lut_cluster_cfg_pkg::*;
#(
  parameter int unsigned K             = 6,
  parameter int unsigned N             = 4,
  parameter logic        INITIAL_VALUE = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  lut_cluster_cfg_if.slave  bus
);

  localparam int unsigned M        = 32'd1 << K;
  localparam int unsigned S        = M + 32'd1;
  localparam int unsigned CFG_BITS = cfg_bits(K, N);
  localparam int unsigned CW       = $clog2(CFG_BITS);

  cfg_state_e          r_state;
  logic [CFG_BITS-1:0] r_cfg;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
`ifdef CFG_CHAIN_OUT_EN
  logic                r_cfg_out;
`endif

  logic         w_accept;
  logic         w_last;
  logic         w_enable;
  logic [N-1:0] w_ble_out;

  // cfg_start wins over cfg_valid; its data bit is dropped.
  assign w_accept = (r_state == ST_LOADING) && bus.cfg_valid && !bus.cfg_start;
  assign w_last   = w_accept && (r_cnt == CW'(CFG_BITS - 1));
  assign w_enable = (r_state == ST_ACTIVE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_UNCONFIG;
      r_cfg     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
`ifdef CFG_CHAIN_OUT_EN
      r_cfg_out <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.cfg_start) begin
        r_state <= ST_LOADING;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_cfg <= {bus.cfg_data, r_cfg[CFG_BITS-1:1]};
`ifdef CFG_CHAIN_OUT_EN
        r_cfg_out <= r_cfg[0];
`endif
        if (w_last) begin
          r_state <= ST_ACTIVE;
          r_cnt   <= '0;
          r_done  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // BLE i owns r_cfg[i*S +: S]: bit 0 is ff_sel, bits 1..M are the LUT mask.
  for (genvar i = 0; i < N; i++) begin : g_ble
    lut_cluster_cfg_ble_cell #(
      .K             (K),
      .INITIAL_VALUE (INITIAL_VALUE)
    ) u_ble (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_mask      (r_cfg[i*S+1 +: M]),
      .i_ff_sel    (r_cfg[i*S]),
      .i_lut_in    (bus.lut_in[i*K +: K]),
      .i_enable    (w_enable),
      .i_load_init (bus.cfg_start),
      .o_out_c     (w_ble_out[i])
    );
  end

  assign bus.out        = w_enable ? w_ble_out : '0;
  assign bus.cfg_active = w_enable;
  assign bus.cfg_done   = r_done;
`ifdef CFG_CHAIN_OUT_EN
  assign bus.cfg_out    = r_cfg_out;
`endif

endmodule

// File: tb/tb_lut_cluster_cfg.sv
// Directed bench for lut_cluster_cfg with K=2, N=2 (10 configuration bits).
module tb_lut_cluster_cfg;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  int   d0;

  // Shift-order vectors: bit [i] is the i-th bit shifted, which equals the final C.
  // A: BLE0 comb AND, BLE1 registered XOR.  B: BLE0 comb OR, BLE1 registered XOR.
  localparam logic [9:0] SEQ_A = 10'b0110110000;
  localparam logic [9:0] SEQ_B = 10'b0110111100;

  lut_cluster_cfg_if #(.K(2), .N(2)) bus ();

  lut_cluster_cfg #(
    .K             (2),
    .N             (2),
    .INITIAL_VALUE (1'b0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef CFG_CHAIN_OUT_EN
  logic [9:0] chain_exp;
  bit         chain_on;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus.cfg_done) done_cnt++;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic load(input logic [9:0] seq, input int gap);
    for (int i = 0; i < 10; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = seq[i];
      tick();
      bus.cfg_valid = 1'b0;
`ifdef CFG_CHAIN_OUT_EN
      if (chain_on) check($sformatf("cfg_out_%0d", i), 8'(bus.cfg_out), 8'(chain_exp[i]));
`endif
      if (i < 9) begin
        check($sformatf("active_mid_%0d", i), 8'(bus.cfg_active), 8'd0);
        check($sformatf("out_mid_%0d", i), 8'(bus.out), 8'd0);
        repeat (gap) tick();
      end
    end
    check("done_after_last", 8'(bus.cfg_done), 8'd1);
    check("active_after_last", 8'(bus.cfg_active), 8'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    done_cnt      = 0;
    reset_n       = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 1'b0;
    bus.lut_in    = 4'hF;
`ifdef CFG_CHAIN_OUT_EN
    chain_on  = 1'b0;
    chain_exp = '0;
`endif
    #1;
    check("rst_out", 8'(bus.out), 8'd0);
    check("rst_active", 8'(bus.cfg_active), 8'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Unconfigured: stray cfg_valid ignored, nothing drives out.
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 1'b1;
    repeat (4) tick();
    bus.cfg_valid = 1'b0;
    check("unconf_out", 8'(bus.out), 8'd0);
    check("unconf_active", 8'(bus.cfg_active), 8'd0);
    check("unconf_done_cnt", 8'(done_cnt), 8'd0);
`ifdef CFG_CHAIN_OUT_EN
    check("rst_cfg_out", 8'(bus.cfg_out), 8'd0);
`endif

    // Load A: AND on BLE0 comb, XOR on BLE1 registered.
    start_load();
    check("loading_active", 8'(bus.cfg_active), 8'd0);
    d0 = done_cnt;
    load(SEQ_A, 0);
    tick();
    check("done_one_cycle", 8'(bus.cfg_done), 8'd0);
    check("done_count_a", 8'(done_cnt - d0), 8'd1);
    bus.lut_in = 4'b11_11;
    #1 check("a_1111_comb", 8'(bus.out), 8'b01);
    tick();
    check("a_1111_reg", 8'(bus.out), 8'b01);
    bus.lut_in = 4'b01_01;
    #1 check("a_0101_comb", 8'(bus.out), 8'b00);
    tick();
    check("a_0101_reg", 8'(bus.out), 8'b10);
    bus.lut_in = 4'b10_01;
    #1 check("a_1001_comb", 8'(bus.out), 8'b10);
    bus.lut_in = 4'b00_11;
    #1 check("a_0011_comb", 8'(bus.out), 8'b11);
    tick();
    check("a_0011_reg", 8'(bus.out), 8'b01);

    // Restart with cfg_start+cfg_valid together: that bit is dropped.
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    check("restart_active", 8'(bus.cfg_active), 8'd0);
    check("restart_out", 8'(bus.out), 8'd0);
`ifdef CFG_CHAIN_OUT_EN
    chain_on  = 1'b1;
    chain_exp = SEQ_A;
`endif
    load(SEQ_B, 0);
`ifdef CFG_CHAIN_OUT_EN
    chain_on = 1'b0;
`endif
    bus.lut_in = 4'b00_01;
    #1 check("b_or_01", 8'(bus.out[0]), 8'd1);
    bus.lut_in = 4'b00_00;
    #1 check("b_or_00", 8'(bus.out[0]), 8'd0);
    bus.lut_in = 4'b00_10;
    #1 check("b_or_10", 8'(bus.out[0]), 8'd1);

    // Partial load interrupted by reset, then full reload.
    start_load();
    for (int i = 0; i < 6; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = SEQ_A[i];
      tick();
    end
    bus.cfg_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_out", 8'(bus.out), 8'd0);
    check("midrst_active", 8'(bus.cfg_active), 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst_still_unconf", 8'(bus.cfg_active), 8'd0);
    start_load();
    d0 = done_cnt;
    load(SEQ_A, 0);
    tick();
    check("done_count_reload", 8'(done_cnt - d0), 8'd1);
    bus.lut_in = 4'b00_11;
    #1 check("reload_and_11", 8'(bus.out[0]), 8'd1);
    bus.lut_in = 4'b00_10;
    #1 check("reload_and_10", 8'(bus.out[0]), 8'd0);

    // Gapped load (3 idle cycles between bits) gives the same behaviour.
    start_load();
    d0 = done_cnt;
    load(SEQ_A, 3);
    tick();
    check("done_count_gap", 8'(done_cnt - d0), 8'd1);
    bus.lut_in = 4'b01_11;
    #1 check("gap_0111_comb", 8'(bus.out), 8'b01);
    tick();
    check("gap_0111_reg", 8'(bus.out), 8'b11);

    // cfg_valid while ACTIVE must not shift the configuration.
    d0 = done_cnt;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 1'b1;
    repeat (3) tick();
    bus.cfg_valid = 1'b0;
    check("act_valid_active", 8'(bus.cfg_active), 8'd1);
    check("act_valid_no_done", 8'(done_cnt - d0), 8'd0);
    bus.lut_in = 4'b00_10;
    #1 check("act_valid_and_10", 8'(bus.out[0]), 8'd0);
    bus.lut_in = 4'b00_11;
    #1 check("act_valid_and_11", 8'(bus.out[0]), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
